dmem_responder: RTL and testbench

// - Data-memory responder on the far end of the CPU core's MEM-stage interface (mem_w, DMType_out, Addr_out, Data_out, Data_in).
// - Performs sub-word stores with byte lanes and returns sign/zero-extended loads in the same cycle.
// - After reset, a sequential clear engine zeroes the array one word per cycle. ready goes high only when the clear completes.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the CPU core (master) and dmem_responder (slave).
// Carries the store strobe, access type, address/data, load return, debug port and error flags.
interface dmem_responder_if #(
    parameter int AW = 7
);
    // No valid/ready handshake: mem_w is a single-cycle store strobe that the
    // responder always accepts at the next rising edge; loads are purely
    // combinational from addr/dm_type. ready only reports that the array is usable.
    logic          mem_w;
    logic [2:0]    dm_type;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] dbg_idx;
    logic [31:0]   dbg_word;
    logic          err;
    logic [31:0]   err_addr;
    logic          dbg_state;

    modport master (
        output mem_w, dm_type, addr, wdata, dbg_idx,
        input  rdata, ready, dbg_word, err, err_addr, dbg_state
    );

    modport slave (
        input  mem_w, dm_type, addr, wdata, dbg_idx,
        output rdata, ready, dbg_word, err, err_addr, dbg_state
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane stores, zero-latency extended loads, post-reset clear engine.
// Optional macro DMEM_MISALIGN_EN: drop/zero misaligned W/H accesses and latch the first offender.
module dmem_responder #(
    parameter int          AW        = 7,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int          DEPTH = 1 << AW;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] clr_idx_next;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] widx;
    logic [1:0]    lane;

    logic          is_half;
    logic          is_byte;
    logic          is_word;
    logic          sign_ext;
    logic          misalign;

    logic [31:0]   rd_word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_val;

    logic [3:0]    store_be;
    logic [31:0]   store_data;
    logic          store_en;

    logic          err_q;
    logic [31:0]   err_addr_q;

    // Address decode; BASE_ADDR is word aligned so the lane comes from the offset.
    assign off      = bus.addr - BASE_ADDR;
    assign in_range = (bus.addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign widx     = off[AW+1:2];
    assign lane     = off[1:0];

    always_comb begin
        is_half  = 1'b0;
        is_byte  = 1'b0;
        sign_ext = 1'b0;
        case (bus.dm_type)
            3'b001: begin
                is_half  = 1'b1;
                sign_ext = 1'b1;
            end
            3'b010: is_half = 1'b1;
            3'b011: begin
                is_byte  = 1'b1;
                sign_ext = 1'b1;
            end
            3'b100: is_byte = 1'b1;
            default: ;
        endcase
    end

    assign is_word = !is_half && !is_byte;

`ifdef DMEM_MISALIGN_EN
    assign misalign = (state == RUN) &&
                      ((is_word && (lane != 2'b00)) || (is_half && lane[0]));
`else
    // Without the check, W ignores lane and H ignores lane[0] (force-aligned).
    assign misalign = 1'b0;
`endif

    // FSM: CLEAR walks every word once, then RUN holds until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == {AW{1'b1}}) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // Load path: reads the current array contents, so a same-cycle store is not visible yet.
    always_comb begin
        rd_word  = mem[widx];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase

        load_val = rd_word;
        if (is_half) begin
            load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
        end else if (is_byte) begin
            load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        end

        if ((state != RUN) || !in_range || misalign) begin
            load_val = '0;
        end
    end

    always_comb begin
        store_be   = 4'b1111;
        store_data = bus.wdata;
        if (is_half) begin
            store_be   = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{bus.wdata[15:0]}};
        end else if (is_byte) begin
            store_be   = 4'b0001 << lane;
            store_data = {4{bus.wdata[7:0]}};
        end
    end

    assign store_en = bus.mem_w && (state == RUN) && in_range && !misalign;

    // Single write port shared by the clear engine and CPU stores; they never overlap in state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (store_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (store_be[i]) begin
                        mem[widx][8*i +: 8] <= store_data[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_EN
    // Sticky: only the first misaligned address is kept until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (misalign && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= bus.addr;
        end
    end
`else
    assign err_q      = 1'b0;
    assign err_addr_q = '0;
`endif

    assign bus.rdata     = load_val;
    assign bus.ready     = (state == RUN);
    assign bus.dbg_word  = mem[bus.dbg_idx];
    assign bus.dbg_state = state;
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed lane/range/clear cases plus random traffic
// compared every cycle against a word-array reference model.
module tb_dmem_responder;
    localparam int          AW    = 7;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic reset;

    dmem_responder_if #(.AW(AW)) bus ();

    dmem_responder #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, cycles since reset release, sticky error
    logic [31:0] exp_mem [DEPTH];
    int          rel_cnt = 0;
    logic        err_exp = 1'b0;
    logic [31:0] err_addr_exp = '0;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
    endfunction

    function automatic bit misal(input logic [2:0] ty, input logic [31:0] a);
`ifdef DMEM_MISALIGN_EN
        if (ty == 3'd1 || ty == 3'd2) return a[0];
        if (ty == 3'd3 || ty == 3'd4) return 1'b0;
        return a[1:0] != 2'b00;
`else
        return (ty == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] ty, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int          sh;
        if (rel_cnt < DEPTH || !in_rng(a) || misal(ty, a)) return 32'h0;
        w = exp_mem[(a - BASE) / 4];
        case (ty)
            3'd1, 3'd2: begin
                sh = a[1] ? 16 : 0;
                v  = (w >> sh) & 32'h0000_FFFF;
                if (ty == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            3'd3, 3'd4: begin
                sh = 8 * int'(a[1:0]);
                v  = (w >> sh) & 32'h0000_00FF;
                if (ty == 3'd3 && v[7]) v = v | 32'hFFFF_FF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] wd);
        int          idx;
        int          sh;
        logic [31:0] mask;
        logic [31:0] w;
        idx = (a - BASE) / 4;
        w   = exp_mem[idx];
        case (ty)
            3'd1, 3'd2: begin
                sh   = a[1] ? 16 : 0;
                mask = 32'h0000_FFFF << sh;
                w    = (w & ~mask) | ((wd & 32'h0000_FFFF) << sh);
            end
            3'd3, 3'd4: begin
                sh   = 8 * int'(a[1:0]);
                mask = 32'h0000_00FF << sh;
                w    = (w & ~mask) | ((wd & 32'h0000_00FF) << sh);
            end
            default: w = wd;
        endcase
        exp_mem[idx] = w;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            rel_cnt      = 0;
            err_exp      = 1'b0;
            err_addr_exp = '0;
        end else if (rel_cnt >= DEPTH) begin
            if (misal(bus.dm_type, bus.addr)) begin
                if (!err_exp) begin
                    err_exp      = 1'b1;
                    err_addr_exp = bus.addr;
                end
            end else if (bus.mem_w && in_rng(bus.addr)) begin
                model_store(bus.dm_type, bus.addr, bus.wdata);
            end
        end else begin
            rel_cnt++;
            if (rel_cnt == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("ready", {31'b0, bus.ready}, (rel_cnt >= DEPTH) ? 32'd1 : 32'd0);
            check("rdata", bus.rdata, model_load(bus.dm_type, bus.addr));
            if (rel_cnt >= DEPTH) check("dbg_word", bus.dbg_word, exp_mem[bus.dbg_idx]);
            check("err", {31'b0, bus.err}, {31'b0, err_exp});
            check("err_addr", bus.err_addr, err_addr_exp);
        end
    end

    // Driver tasks
    task automatic drive(input logic mw, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.mem_w   = mw;
        bus.dm_type = ty;
        bus.addr    = a;
        bus.wdata   = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string name, input logic [2:0] ty, input logic [31:0] a,
                              input logic [31:0] exp);
        drive(1'b0, ty, a, 32'h0);
        #1;
        check(name, bus.rdata, exp);
    endtask

    // Counts edges after release until ready; a store to word 0 is injected at inject_at.
    task automatic wait_ready(input int inject_at, output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            n = k;
            if (bus.ready) break;
            if (k == inject_at) drive(1'b1, 3'd0, 32'h0, 32'hDEAD_BEEF);
            else drive(1'b0, 3'd0, 32'h0, 32'h0);
        end
    endtask

    task automatic scan_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            bus.dbg_idx = AW'(i);
            #1;
            check(name, bus.dbg_word, 32'h0);
        end
        bus.dbg_idx = '0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.dbg_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, bus.ready}, 32'd0);
        reset = 1'b0;

        // Clear engine with a dropped store during CLEAR
        wait_ready(5, n);
        check("clear_cycles", n, 32'd128);
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        scan_zero("dbg_after_clear");
        load_check("clear_store_dropped", 3'd0, 32'h0, 32'h0);

        // Byte lanes
        drive(1'b1, 3'd0, 32'h10, 32'h1122_3344); step();
        drive(1'b1, 3'd3, 32'h11, 32'h0000_00AB); step();
        drive(1'b1, 3'd1, 32'h12, 32'h0000_BEEF); step();
        load_check("lw_10",  3'd0, 32'h10, 32'hBEEF_AB44);
        load_check("lb_11",  3'd3, 32'h11, 32'hFFFF_FFAB);
        load_check("lbu_11", 3'd4, 32'h11, 32'h0000_00AB);
        load_check("lh_12",  3'd1, 32'h12, 32'hFFFF_BEEF);
        load_check("lhu_12", 3'd2, 32'h12, 32'h0000_BEEF);
        step();

        // Read-during-write
        drive(1'b1, 3'd0, 32'h20, 32'hCAFE_F00D);
        #1;
        check("rdw_old", bus.rdata, 32'h0);
        step();
        bus.mem_w = 1'b0;
        #1;
        check("rdw_new", bus.rdata, 32'hCAFE_F00D);

        // Range
        drive(1'b1, 3'd0, 32'h200, 32'h1234_5678); step();
        load_check("range_lw", 3'd0, 32'h200, 32'h0);
        load_check("range_mem0", 3'd0, 32'h0, 32'h0);
        step();

        // Misaligned word store
        drive(1'b1, 3'd0, 32'h22, 32'h0000_0055); step();
`ifdef DMEM_MISALIGN_EN
        load_check("misal_lw_20", 3'd0, 32'h20, 32'hCAFE_F00D);
        check("misal_err", {31'b0, bus.err}, 32'd1);
        check("misal_err_addr", bus.err_addr, 32'h22);
        load_check("misal_lh_23", 3'd1, 32'h23, 32'h0);
        step();
        check("misal_err_addr_hold", bus.err_addr, 32'h22);
`else
        load_check("align_lw_20", 3'd0, 32'h20, 32'h0000_0055);
        check("align_err", {31'b0, bus.err}, 32'd0);
        step();
`endif

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ? 32'($urandom_range(512, 1023))
                                              : 32'($urandom_range(0, 511)),
                  $urandom);
            bus.dbg_idx = AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);

        // Reset mid-clear restarts the clear
        reset = 1'b1; step();
        reset = 1'b0;
        repeat (60) step();
        check("midclear_ready", {31'b0, bus.ready}, 32'd0);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        wait_ready(-1, n);
        check("reclear_cycles", n, 32'd128);
        scan_zero("dbg_after_reclear");
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
